// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter with bounded bursts; grants one cycle after arbitration in IDLE, read data one cycle after the transfer.
// Backpressure: a requester waits with req held until x_gnt; fields are passed through unregistered during a transfer.
module dmem_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [3:0]  a_we,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_we,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [31:0] b_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic       OWNER_A  = 1'b0;
  localparam logic       OWNER_B  = 1'b1;
  localparam logic [3:0] BEAT_LIM = 4'(BURST_MAX);

  state_t     state, state_nxt;
  logic       last_owner, last_owner_nxt;
  logic [3:0] beats, beats_nxt;
  logic [3:0] beats_inc;
  logic       a_rd, b_rd;

  // Grants depend only on the async-reset state, so reset kills mem_we immediately.
  assign a_gnt     = a_req && (state == OWN_A);
  assign b_gnt     = b_req && (state == OWN_B);
  assign a_rd      = a_gnt && (a_we == 4'b0000);
  assign b_rd      = b_gnt && (b_we == 4'b0000);
  assign beats_inc = beats + 4'd1;

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = '0;
    if (a_gnt) begin
      mem_addr = a_addr;
      mem_din  = a_wdata;
      mem_we   = a_we;
    end else if (b_gnt) begin
      mem_addr = b_addr;
      mem_din  = b_wdata;
      mem_we   = b_we;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    beats_nxt      = beats;
    case (state)
      IDLE: begin
        beats_nxt = '0;
        if (a_req && (!b_req || last_owner == OWNER_B)) begin
          state_nxt = OWN_A;
        end else if (b_req) begin
          state_nxt = OWN_B;
        end
      end
      OWN_A: begin
        if (!a_req || beats_inc == BEAT_LIM) begin
          last_owner_nxt = OWNER_A;
          beats_nxt      = '0;
          state_nxt      = b_req ? OWN_B : IDLE;
        end else begin
          beats_nxt = beats_inc;
        end
      end
      OWN_B: begin
        if (!b_req || beats_inc == BEAT_LIM) begin
          last_owner_nxt = OWNER_B;
          beats_nxt      = '0;
          state_nxt      = a_req ? OWN_A : IDLE;
        end else begin
          beats_nxt = beats_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        beats_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_owner <= OWNER_B;
      beats      <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      beats      <= beats_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_rd;
      b_rvalid <= b_rd;
      if (a_rd) a_rdata <= mem_dout;
      if (b_rd) b_rdata <= mem_dout;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, b_req;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [3:0]  a_we, b_we;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic [3:0]  mem_we;

  logic [31:0] mem_arr [256];
  logic [31:0] ref_mem [256];

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_we(a_we),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_we(b_we),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Environment memory: combinational read, byte-enabled write.
  assign mem_dout = mem_arr[mem_addr[9:2]];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (mem_we[k]) mem_arr[mem_addr[9:2]][8*k +: 8] <= mem_din[8*k +: 8];
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    a_req = 0; b_req = 0; a_we = 0; b_we = 0;
    a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    idle_inputs();
    a_req = 1; b_req = 1; a_we = 4'hF; b_we = 4'hF;
    tick(); tick();
    #1;
    checks++;
    if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b exp=0000", {a_gnt, b_gnt, a_rvalid, b_rvalid});
    end
    checks++;
    if ({a_rdata, b_rdata, mem_addr, mem_din, mem_we} !== '0) begin
      errors++; $display("FAIL reset_data rdata=%h/%h mem=%h/%h/%h exp all 0", a_rdata, b_rdata, mem_addr, mem_din, mem_we);
    end
    idle_inputs();
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_single_read();
    mem_arr[4] <= 32'hDEADBEEF;
    a_req = 1; a_we = 0; a_addr = 32'h10;
    #1;
    checks++;
    if (a_gnt !== 1'b0) begin errors++; $display("FAIL read_c1_gnt got=%b exp=0", a_gnt); end
    tick(); #1;
    checks++;
    if (a_gnt !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 4'h0) begin
      errors++; $display("FAIL read_c2 gnt=%b addr=%h we=%h exp 1/10/0", a_gnt, mem_addr, mem_we);
    end
    tick(); a_req = 0; #1;
    checks++;
    if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_c3 rvalid=%b rdata=%h exp 1/deadbeef", a_rvalid, a_rdata);
    end
    tick(); #1;
    checks++;
    if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL read_hold rvalid=%b rdata=%h exp 0/deadbeef", a_rvalid, a_rdata);
    end
    tick();
  endtask

  task automatic test_tie();
    logic [1:0] exp_g;
    reset = 0; idle_inputs(); tick(); reset = 1;
    a_req = 1; b_req = 1; a_addr = 32'h40; b_addr = 32'h44;
    for (int c = 0; c <= 12; c++) begin
      #1;
      if (c == 0) exp_g = 2'b00;
      else exp_g = (((c - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if ({a_gnt, b_gnt} !== exp_g) begin
        errors++; $display("FAIL tie_cycle%0d gnt_ab got=%b exp=%b", c, {a_gnt, b_gnt}, exp_g);
      end
      tick();
    end
    a_req = 0; b_req = 0;
    tick(); tick();
  endtask

  task automatic test_byte_write();
    mem_arr[8] <= 32'h11223344;
    b_req = 1; b_we = 4'b0010; b_wdata = 32'h0000AB00; b_addr = 32'h20;
    #1;
    checks++;
    if (b_gnt !== 1'b0 || mem_we !== 4'h0) begin
      errors++; $display("FAIL bw_idle gnt=%b we=%h exp 0/0", b_gnt, mem_we);
    end
    tick(); #1;
    checks++;
    if (b_gnt !== 1'b1 || mem_we !== 4'b0010 || mem_din !== 32'h0000AB00 || mem_addr !== 32'h20) begin
      errors++; $display("FAIL bw_xfer gnt=%b we=%b din=%h addr=%h exp 1/0010/0000ab00/20", b_gnt, mem_we, mem_din, mem_addr);
    end
    tick(); b_req = 0; #1;
    checks++;
    if (mem_we !== 4'h0 || b_rvalid !== 1'b0) begin
      errors++; $display("FAIL bw_after we=%h rvalid=%b exp 0/0", mem_we, b_rvalid);
    end
    tick(); #1;
    checks++;
    if (b_rvalid !== 1'b0) begin errors++; $display("FAIL bw_no_rvalid got=%b exp=0", b_rvalid); end
    b_we = 0; b_req = 1;
    tick(); #1;
    checks++;
    if (b_gnt !== 1'b1) begin errors++; $display("FAIL bw_read_gnt got=%b exp=1", b_gnt); end
    tick(); b_req = 0; #1;
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'h1122AB44) begin
      errors++; $display("FAIL bw_readback rvalid=%b rdata=%h exp 1/1122ab44", b_rvalid, b_rdata);
    end
    tick();
  endtask

  task automatic test_early_release();
    a_req = 1; a_we = 4'hF; a_addr = 32'h30; a_wdata = $urandom;
    #1;
    checks++;
    if (a_gnt !== 1'b0) begin errors++; $display("FAIL er_idle gnt=%b exp=0", a_gnt); end
    for (int c = 0; c < 2; c++) begin
      tick(); #1;
      checks++;
      if (a_gnt !== 1'b1 || mem_we !== 4'hF) begin
        errors++; $display("FAIL er_beat%0d gnt=%b we=%h exp 1/f", c, a_gnt, mem_we);
      end
    end
    tick(); a_req = 0; #1;
    checks++;
    if (a_gnt !== 1'b0 || mem_we !== 4'h0) begin
      errors++; $display("FAIL er_drop gnt=%b we=%h exp 0/0", a_gnt, mem_we);
    end
    tick(); a_req = 1; a_we = 0; #1;
    checks++;
    if (a_gnt !== 1'b0) begin errors++; $display("FAIL er_back_in_idle gnt=%b exp=0", a_gnt); end
    tick(); b_req = 1; b_we = 0; b_addr = 32'h24;
    // A must now get a full burst, proving the beat count restarted from zero.
    for (int c = 0; c <= 4; c++) begin
      #1;
      checks++;
      if ({a_gnt, b_gnt} !== ((c < 4) ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL er_fullburst%0d gnt_ab got=%b exp=%b", c, {a_gnt, b_gnt}, (c < 4) ? 2'b10 : 2'b01);
      end
      tick();
    end
    a_req = 0; b_req = 0;
    tick(); tick();
  endtask

  task automatic test_reset_mid_burst();
    a_req = 1; a_we = 0; a_addr = 32'h10;
    tick(); #1;
    checks++;
    if (a_gnt !== 1'b1) begin errors++; $display("FAIL rm_first_gnt got=%b exp=1", a_gnt); end
    tick(); #1;
    checks++;
    if (a_rvalid !== 1'b1 || a_gnt !== 1'b1) begin
      errors++; $display("FAIL rm_pre rvalid=%b gnt=%b exp 1/1", a_rvalid, a_gnt);
    end
    reset = 0; #1;
    checks++;
    if (a_rvalid !== 1'b0 || a_gnt !== 1'b0 || mem_we !== 4'h0 || mem_addr !== 32'h0 || a_rdata !== 32'h0) begin
      errors++; $display("FAIL rm_abort rvalid=%b gnt=%b we=%h addr=%h rdata=%h exp all 0", a_rvalid, a_gnt, mem_we, mem_addr, a_rdata);
    end
    a_req = 0; b_req = 1; b_we = 0; b_addr = 32'h8;
    tick(); reset = 1; #1;
    checks++;
    if (b_gnt !== 1'b0) begin errors++; $display("FAIL rm_release_gnt got=%b exp=0", b_gnt); end
    tick(); #1;
    checks++;
    if (b_gnt !== 1'b1) begin errors++; $display("FAIL rm_b_granted got=%b exp=1", b_gnt); end
    tick(); b_req = 0;
    tick(); tick();
  endtask

  task automatic test_random();
    int          owner, last, beats;
    logic        m_rv_a, m_rv_b, ga, gb, a_pend, b_pend;
    logic [31:0] m_rd_a, m_rd_b, e_addr, e_din;
    logic [3:0]  e_we;
    reset = 0; idle_inputs();
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = $urandom;
      mem_arr[i] <= w;
      ref_mem[i] = w;
    end
    tick(); reset = 1;
    owner = 0; last = 2; beats = 0;
    m_rv_a = 0; m_rv_b = 0; m_rd_a = 0; m_rd_b = 0; a_pend = 0; b_pend = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!a_pend) begin
        a_req = ($urandom_range(0, 3) != 0);
        a_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        a_wdata = $urandom;
        a_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        a_pend = a_req;
      end
      if (!b_pend) begin
        b_req = ($urandom_range(0, 2) != 0);
        b_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        b_wdata = $urandom;
        b_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        b_pend = b_req;
      end
      #1;
      ga = a_req && owner == 1;
      gb = b_req && owner == 2;
      e_addr = ga ? a_addr : gb ? b_addr : 32'h0;
      e_din  = ga ? a_wdata : gb ? b_wdata : 32'h0;
      e_we   = ga ? a_we : gb ? b_we : 4'h0;
      checks++;
      if ({a_gnt, b_gnt} !== {ga, gb}) begin
        errors++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, {a_gnt, b_gnt}, {ga, gb});
      end
      checks++;
      if (mem_addr !== e_addr || mem_din !== e_din || mem_we !== e_we) begin
        errors++; $display("FAIL rnd_mem cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, mem_addr, mem_din, mem_we, e_addr, e_din, e_we);
      end
      checks++;
      if (a_rvalid !== m_rv_a || (m_rv_a && a_rdata !== m_rd_a)) begin
        errors++; $display("FAIL rnd_a_read cyc=%0d got=%b/%h exp=%b/%h", cyc, a_rvalid, a_rdata, m_rv_a, m_rd_a);
      end
      checks++;
      if (b_rvalid !== m_rv_b || (m_rv_b && b_rdata !== m_rd_b)) begin
        errors++; $display("FAIL rnd_b_read cyc=%0d got=%b/%h exp=%b/%h", cyc, b_rvalid, b_rdata, m_rv_b, m_rd_b);
      end
      checks++;
      if (a_rdata !== m_rd_a || b_rdata !== m_rd_b) begin
        errors++; $display("FAIL rnd_rdata_hold cyc=%0d got=%h/%h exp=%h/%h", cyc, a_rdata, b_rdata, m_rd_a, m_rd_b);
      end
      @(posedge clk);
      m_rv_a = ga && a_we == 0;
      m_rv_b = gb && b_we == 0;
      if (m_rv_a) m_rd_a = ref_mem[a_addr[9:2]];
      if (m_rv_b) m_rd_b = ref_mem[b_addr[9:2]];
      for (int k = 0; k < 4; k++) begin
        if (ga && a_we[k]) ref_mem[a_addr[9:2]][8*k +: 8] = a_wdata[8*k +: 8];
        if (gb && b_we[k]) ref_mem[b_addr[9:2]][8*k +: 8] = b_wdata[8*k +: 8];
      end
      if (ga) a_pend = 0;
      if (gb) b_pend = 0;
      // Ownership rules: round-robin on ties, burst cap of 4, release straight to a waiting peer.
      if (owner == 0) begin
        if (a_req && b_req) owner = (last == 1) ? 2 : 1;
        else if (a_req) owner = 1;
        else if (b_req) owner = 2;
        beats = 0;
      end else begin
        int mine_req, other_req;
        mine_req  = (owner == 1) ? int'(a_req) : int'(b_req);
        other_req = (owner == 1) ? int'(b_req) : int'(a_req);
        if (mine_req == 0 || beats + 1 == 4) begin
          last  = owner;
          owner = (other_req != 0) ? 3 - owner : 0;
          beats = 0;
        end else begin
          beats = beats + 1;
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    reset = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_byte_write();
    test_early_release();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4, giving the max consecutive transfers per ownership (legal range 1..15).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 SHALL have port a_req  input  1  core requester transfer request.
REQ-005 SHALL have port a_addr  input  32  core byte address.
REQ-006 SHALL have port a_wdata  input  32  core write data.
REQ-007 SHALL have port a_we  input  4  core byte write enables; 0 = read.
REQ-008 SHALL have port a_gnt  output  1  core transfer accepted this cycle.
REQ-009 SHALL have port a_rvalid  output  1  core read data valid.
REQ-010 SHALL have port a_rdata  output  32  core read data.
REQ-011 SHALL have ports b_req, b_addr, b_wdata, b_we, b_gnt, b_rvalid, b_rdata, identical in direction, width and meaning to the a_* ports, for the loader/DMA requester.
REQ-012 SHALL have port mem_addr  output  32  data memory address.
REQ-013 SHALL have port mem_din  output  32  data memory write data.
REQ-014 SHALL have port mem_we  output  4  data memory byte write enables.
REQ-015 SHALL have port mem_dout  input  32  data memory read data, combinational from mem_addr.

Function
REQ-016 SHALL implement states IDLE, OWN_A, OWN_B, plus a last_owner flag and a beat counter (0..BURST_MAX).
REQ-017 SHALL drive x_gnt = x_req AND state==OWN_x, combinationally; a transfer occurs in a cycle where x_req and x_gnt are both 1.
REQ-018 SHALL, during a transfer, drive mem_addr/mem_din/mem_we from the granted requester; otherwise drive mem_addr=0, mem_din=0, mem_we=0.
REQ-019 SHALL, for a read transfer (x_we==0), capture mem_dout into x_rdata at that clock edge and assert x_rvalid for exactly the next cycle.
REQ-020 SHALL never assert x_rvalid for a write transfer; x_rdata holds its last value when x_rvalid is 0.
REQ-021 IDLE: only a_req -> OWN_A; only b_req -> OWN_B; both -> the requester not equal to last_owner; neither -> IDLE; no grant is given in IDLE (1-cycle arbitration latency).
REQ-022 SHALL increment the beat counter on each transfer and clear it on every ownership change or entry to IDLE.
REQ-023 OWN_x SHALL release when x_req is 0, or after the transfer that brings the counter to BURST_MAX; on release, last_owner := x.
REQ-024 On release, if the other requester's req is 1, next state SHALL be OWN_other directly (no IDLE cycle); else IDLE.
REQ-025 SHALL never grant both requesters in one cycle, and mem_we SHALL be 0 whenever no grant is asserted.
REQ-026 A requester SHALL hold addr/wdata/we stable while req=1 and gnt=0; the arbiter SHALL not register request fields.

Reset
REQ-027 While reset=0: state=IDLE, last_owner=B (so A wins the first tie), counter=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, all mem_* outputs 0, gnts 0.
REQ-028 Reset assertion mid-burst SHALL abort immediately, drop any pending rvalid, and not corrupt memory (mem_we=0 asynchronously).
REQ-029 After reset deasserts, the first arbitration SHALL occur on the first rising clk edge with reset=1.

Verification
REQ-030 Single read: a_req=1, a_we=0, a_addr=0x10, memory[0x10]=0xDEADBEEF -> a_gnt=1 at cycle 2, a_rvalid=1 and a_rdata=0xDEADBEEF at cycle 3.
REQ-031 Tie after reset: a_req=b_req=1 held -> A gets 4 transfers (BURST_MAX=4), then B without an IDLE cycle, then A again; no cycle with both gnts.
REQ-032 Byte write: b_we=4'b0010, b_wdata=0x0000AB00, b_addr=0x20 -> mem_we=4'b0010 for exactly one cycle; b_rvalid stays 0; a later read returns byte1=0xAB.
REQ-033 Early release: A bursts 2 beats then drops a_req with b_req=0 -> IDLE next cycle; counter reads 0; mem_we=0.
REQ-034 Reset mid-burst: pull reset low during an A read transfer -> a_rvalid=0, mem_we=0, state IDLE immediately; after release with b_req=1 only, B is granted one cycle later.
